nav_frame_rx: RTL and testbench
===============================

NAV_FRAME_RX -- requirements
Module: nav_frame_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning PWM cycles per UART bit (50 MHz / 9600 baud).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 20, meaning the maximum inter-byte gap in bit times before a partial frame is dropped.
REQ-003 SHALL have port PWM, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port EN, input, 1 bit: receive enable.
REQ-006 SHALL have port rx_in, input, 1 bit: asynchronous UART line from the sensor module, idle high.
REQ-007 SHALL have port geo_out, output, 8 bits: last accepted heading byte.
REQ-008 SHALL have port gps_out, output, 8 bits: last accepted latitude byte.
REQ-009 SHALL have port qr_out, output, 1 bit: last accepted QR-present flag.
REQ-010 SHALL have port upd, output, 1 bit: one-cycle pulse per accepted frame.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse per rejected frame.

Function
REQ-012 SHALL pass rx_in through a 2-FF synchronizer before any use.
REQ-013 SHALL detect a start bit on a synchronized high-to-low transition and re-sample it at CLKS_PER_BIT/2; if the line is high there, the receiver SHALL return to idle with no error.
REQ-014 SHALL sample 8 data bits LSB first, each CLKS_PER_BIT cycles after the previous sample, then sample the stop bit.
REQ-015 SHALL treat a low stop bit as a framing error: discard the byte, pulse frame_err, and put the parser in HUNT.
REQ-016 SHALL run the parser FSM with states HUNT, TYPE, DATA and CHK, advancing once per received byte.
REQ-017 In HUNT, byte 0xA5 SHALL move the FSM to TYPE; any other byte SHALL leave it in HUNT with no error.
REQ-018 In TYPE, byte 0x01 (geo), 0x02 (gps) or 0x03 (qr) SHALL be latched and the FSM SHALL move to DATA; byte 0xA5 SHALL keep the FSM in TYPE; any other byte SHALL pulse frame_err and return the FSM to HUNT.
REQ-019 In DATA, the byte SHALL be latched and the FSM SHALL move to CHK.
REQ-020 In CHK, a byte equal to type XOR data SHALL commit the frame; otherwise frame_err SHALL pulse with no output change. The FSM SHALL return to HUNT in both cases.
REQ-021 A commit SHALL update exactly one output (geo_out = data, gps_out = data, or qr_out = data[0]) and pulse upd in the cycle after the checksum stop-bit sample; the output SHALL change in that same cycle.
REQ-022 In TYPE, DATA or CHK, if no byte completes within TIMEOUT_BITS*CLKS_PER_BIT cycles, the parser SHALL pulse frame_err and go to HUNT.
REQ-023 While EN=0, the receiver and parser SHALL be held idle in HUNT, an in-flight byte or partial frame SHALL be dropped silently, and all outputs SHALL hold their values.
REQ-024 upd and frame_err SHALL never be high in the same cycle.

Reset
REQ-025 While RST=1 at a PWM edge, geo_out, gps_out, qr_out, upd and frame_err SHALL be 0, the FSM SHALL be in HUNT, all counters SHALL be 0, and the synchronizer SHALL be 1.
REQ-026 RST SHALL override EN and abort any in-progress byte or frame.

Configuration
REQ-027 With macro NAV_RX_CHECKSUM_EN defined, the frame SHALL be A5, type, data, checksum, per REQ-020.
REQ-028 Without NAV_RX_CHECKSUM_EN, the CHK state SHALL be absent, the frame SHALL be A5, type, data, and the commit SHALL occur on the data byte with the same one-cycle latency.

Structure
REQ-029 A shared package nav_rx_pkg SHALL hold the header constant 0xA5, the type codes 0x01/0x02/0x03, and the parser state enumeration.
REQ-030 Byte reception (synchronizer, bit timing, stop check) SHALL be one sub-module, nav_uart_rx, which outputs an 8-bit byte, a byte-valid pulse, and a framing-error pulse.

Verification (bench: CLKS_PER_BIT=8, TIMEOUT_BITS=20, checksum enabled)
REQ-031 Send bytes A5 01 46 47 -> geo_out=0x46, one upd pulse, gps_out=0, qr_out=0.
REQ-032 Send bytes A5 02 C6 C4 -> gps_out=0xC6, one upd pulse, geo_out unchanged.
REQ-033 Send bytes A5 01 46 00 -> one frame_err pulse, no upd pulse, geo_out unchanged.
REQ-034 Send bytes 12 A5 A5 03 01 02 -> resync, qr_out=1, one upd pulse, no frame_err pulse.
REQ-035 Send bytes A5 01, then hold the line idle for 200 cycles -> one frame_err pulse; a following A5 02 40 42 -> gps_out=0x40.
REQ-036 Send a byte with a low stop bit -> one frame_err pulse; drop EN mid-frame -> outputs hold; assert RST mid-frame -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/nav_rx_pkg.sv
// rtl/nav_rx_pkg.sv - shared constants and state types for the nav frame receiver
// Optional checksum byte and CHK state are enabled by NAV_RX_CHECKSUM_EN.
package nav_rx_pkg;

  localparam logic [7:0] NAV_HDR      = 8'hA5;
  localparam logic [7:0] NAV_TYPE_GEO = 8'h01;
  localparam logic [7:0] NAV_TYPE_GPS = 8'h02;
  localparam logic [7:0] NAV_TYPE_QR  = 8'h03;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_TYPE,
    ST_DATA
`ifdef NAV_RX_CHECKSUM_EN
    , ST_CHK
`endif
  } nav_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_state_e;

  function automatic logic nav_is_type(input logic [7:0] b);
    return (b == NAV_TYPE_GEO) || (b == NAV_TYPE_GPS) || (b == NAV_TYPE_QR);
  endfunction

  function automatic logic [7:0] nav_checksum(input logic [7:0] t, input logic [7:0] d);
    return t ^ d;
  endfunction

endpackage

// File: rtl/nav_uart_rx.sv
// rtl/nav_uart_rx.sv - 8N1 UART byte receiver with input synchronizer and stop-bit check
// byte_valid_o/frame_err_o are combinational pulses in the stop-sample cycle.
module nav_uart_rx
  import nav_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_s;

  assign rx_s   = sync_q[1];
  assign byte_o = shift_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d        = '0;
          state_d      = RX_IDLE;
          byte_valid_o = rx_s;
          frame_err_o  = !rx_s;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    // Disabled: drop any byte in flight; the synchronizer keeps tracking the line.
    if (!en_i) begin
      state_d      = RX_IDLE;
      cnt_d        = '0;
      bit_d        = '0;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;
    end
  end

endmodule

// File: rtl/nav_frame_rx.sv
// rtl/nav_frame_rx.sv - nav sensor frame parser (A5, type, data[, checksum]) over UART
// Define NAV_RX_CHECKSUM_EN to require the trailing type^data checksum byte.
module nav_frame_rx
  import nav_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       PWM,
  input  logic       RST,
  input  logic       EN,
  input  logic       rx_in,
  output logic [7:0] geo_out,
  output logic [7:0] gps_out,
  output logic       qr_out,
  output logic       upd,
  output logic       frame_err
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  nav_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk_i        (PWM),
    .rst_i        (RST),
    .en_i         (EN),
    .rx_i         (rx_in),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  nav_state_e    state_q, state_d;
  logic [7:0]    type_q, type_d;
`ifdef NAV_RX_CHECKSUM_EN
  logic [7:0]    data_q, data_d;
`endif
  logic [7:0]    geo_q, geo_d, gps_q, gps_d;
  logic          qr_q, qr_d, upd_q, upd_d, err_q, err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          commit;
  logic [7:0]    commit_data;

  assign geo_out   = geo_q;
  assign gps_out   = gps_q;
  assign qr_out    = qr_q;
  assign upd       = upd_q;
  assign frame_err = err_q;

  always_ff @(posedge PWM) begin
    if (RST) begin
      state_q  <= ST_HUNT;
      type_q   <= '0;
`ifdef NAV_RX_CHECKSUM_EN
      data_q   <= '0;
`endif
      geo_q    <= '0;
      gps_q    <= '0;
      qr_q     <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
`ifdef NAV_RX_CHECKSUM_EN
      data_q   <= data_d;
`endif
      geo_q    <= geo_d;
      gps_q    <= gps_d;
      qr_q     <= qr_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
`ifdef NAV_RX_CHECKSUM_EN
    data_d      = data_q;
`endif
    geo_d       = geo_q;
    gps_d       = gps_q;
    qr_d        = qr_q;
    upd_d       = 1'b0;
    err_d       = 1'b0;
    commit      = 1'b0;
    commit_data = '0;
    // Inter-byte gap timer only runs while a frame is partially received.
    to_cnt_d    = (state_q == ST_HUNT) ? '0 : to_cnt_q + 1'b1;

    if (rx_err) begin
      state_d  = ST_HUNT;
      err_d    = 1'b1;
      to_cnt_d = '0;
    end else if (rx_valid) begin
      to_cnt_d = '0;
      case (state_q)
        ST_HUNT: if (rx_byte == NAV_HDR) state_d = ST_TYPE;
        ST_TYPE: begin
          if (nav_is_type(rx_byte)) begin
            type_d  = rx_byte;
            state_d = ST_DATA;
          end else if (rx_byte == NAV_HDR) begin
            state_d = ST_TYPE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end
        end
`ifdef NAV_RX_CHECKSUM_EN
        ST_DATA: begin
          data_d  = rx_byte;
          state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_HUNT;
          if (rx_byte == nav_checksum(type_q, data_q)) begin
            commit      = 1'b1;
            commit_data = data_q;
          end else begin
            err_d = 1'b1;
          end
        end
`else
        ST_DATA: begin
          state_d     = ST_HUNT;
          commit      = 1'b1;
          commit_data = rx_byte;
        end
`endif
        default: state_d = ST_HUNT;
      endcase
    end else if (state_q != ST_HUNT && to_cnt_q == TO_LAST) begin
      err_d    = 1'b1;
      state_d  = ST_HUNT;
      to_cnt_d = '0;
    end

    if (commit) begin
      upd_d = 1'b1;
      case (type_q)
        NAV_TYPE_GEO: geo_d = commit_data;
        NAV_TYPE_GPS: gps_d = commit_data;
        default:      qr_d  = commit_data[0];
      endcase
    end

    if (!EN) begin
      state_d  = ST_HUNT;
      to_cnt_d = '0;
      upd_d    = 1'b0;
      err_d    = 1'b0;
      geo_d    = geo_q;
      gps_d    = gps_q;
      qr_d     = qr_q;
    end
  end

endmodule

// File: tb/tb_nav_frame_rx.sv
// tb/tb_nav_frame_rx.sv - scoreboard bench for nav_frame_rx (CLKS_PER_BIT=8, TIMEOUT_BITS=20)
// Expectations adapt to whether NAV_RX_CHECKSUM_EN is defined.
module tb_nav_frame_rx;

  localparam int CPB = 8;
  localparam int TOB = 20;

  logic       PWM = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] geo_out, gps_out;
  logic       qr_out, upd, frame_err;

  nav_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .PWM       (PWM),
    .RST       (RST),
    .EN        (EN),
    .rx_in     (rx_in),
    .geo_out   (geo_out),
    .gps_out   (gps_out),
    .qr_out    (qr_out),
    .upd       (upd),
    .frame_err (frame_err)
  );

  always #5 PWM = ~PWM;

  typedef struct packed {
    logic       err;
    logic [7:0] geo;
    logic [7:0] gps;
    logic       qr;
  } evt_t;

  evt_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         both_cnt = 0;
  logic [7:0] m_geo = 8'h00;
  logic [7:0] m_gps = 8'h00;
  logic       m_qr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge PWM);
  endtask

  task automatic push(input logic err);
    evt_t e;
    e.err = err;
    e.geo = m_geo;
    e.gps = m_gps;
    e.qr  = m_qr;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx_in = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      cyc(CPB);
    end
    rx_in = stop;
    cyc(CPB);
    rx_in = 1'b1;
    cyc(4);
  endtask

  task automatic drain(input string tag);
    cyc(12);
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: every upd/frame_err pulse consumes one expected event.
  always @(negedge PWM) begin
    evt_t e;
    if (!RST) begin
      if (upd && frame_err) both_cnt++;
      if (upd || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {upd, frame_err}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("event", {frame_err, upd, geo_out, gps_out, qr_out},
                {e.err, ~e.err, e.geo, e.gps, e.qr});
        end
      end
    end
  end

  initial begin
    cyc(3);
    check("rst_geo", geo_out, 0);
    check("rst_gps", gps_out, 0);
    check("rst_qr", qr_out, 0);
    check("rst_upd", upd, 0);
    check("rst_err", frame_err, 0);
    RST = 1'b0;
    EN  = 1'b1;
    cyc(5);

    m_geo = 8'h46; push(1'b0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h46); send_byte(8'h47);
    drain("geo_frame");
    check("geo_value", geo_out, 8'h46);

    m_gps = 8'hC6; push(1'b0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC6); send_byte(8'hC4);
    drain("gps_frame");

`ifdef NAV_RX_CHECKSUM_EN
    push(1'b1);
`else
    push(1'b0);
`endif
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h46); send_byte(8'h00);
    drain("bad_checksum");
    check("geo_after_bad", geo_out, 8'h46);

    m_qr = 1'b1; push(1'b0);
    send_byte(8'h12); send_byte(8'hA5); send_byte(8'hA5);
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h02);
    drain("resync_qr");

    push(1'b1);
    send_byte(8'hA5); send_byte(8'h01);
    cyc(200);
    drain("timeout");
    m_gps = 8'h40; push(1'b0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h40); send_byte(8'h42);
    drain("after_timeout");
    check("gps_value", gps_out, 8'h40);

    push(1'b1);
    send_byte(8'h55, 1'b0);
    drain("stop_bit_low");

    send_byte(8'hA5); send_byte(8'h01);
    rx_in = 1'b0;
    cyc(CPB * 2);
    EN = 1'b0;
    rx_in = 1'b1; cyc(CPB * 3);
    rx_in = 1'b0; cyc(CPB * 5);
    rx_in = 1'b1; cyc(CPB * 4);
    check("en_hold_geo", geo_out, 8'h46);
    check("en_hold_gps", gps_out, 8'h40);
    check("en_hold_qr", qr_out, 1'b1);
    EN = 1'b1;
    cyc(TOB * CPB + 20);
    drain("en_drop_silent");
    m_qr = 1'b0; push(1'b0);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(8'h03);
    drain("after_en");

    send_byte(8'hA5); send_byte(8'h01);
    rx_in = 1'b0;
    cyc(CPB * 3);
    RST = 1'b1;
    @(posedge PWM);
    #1;
    check("midrst_geo", geo_out, 0);
    check("midrst_gps", gps_out, 0);
    check("midrst_qr", qr_out, 0);
    check("midrst_upd", upd, 0);
    check("midrst_err", frame_err, 0);
    m_geo = 8'h00; m_gps = 8'h00; m_qr = 1'b0;
    cyc(2);
    rx_in = 1'b1;
    RST = 1'b0;
    cyc(CPB * 12);
    drain("post_reset_quiet");
    m_gps = 8'hC6; push(1'b0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC6); send_byte(8'hC4);
    drain("post_reset_frame");
    check("post_reset_geo", geo_out, 8'h00);

    check("upd_err_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
